// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared definitions for the streaming 2-D pooling stage. Holds
//            the pooling-mode encodings, a constant ceil(log2) helper and
//            the per-lane accumulator width helper.
// Revision : 1.0 - initial release
// ============================================================================
package pool_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Accumulator width per lane: sample width plus headroom for POOL*POOL adds
  function automatic int lane_acc_w(input int data_w, input int pool);
    return data_w + 2 * clog2(pool);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_lane.sv
`default_nettype none
// ============================================================================
// Module   : pool_lane
// Purpose  : Per-lane window arithmetic. Produces the updated line-buffer
//            entry (max or running sum) and the pooled result derived from it.
// Ports    : mode      - pooling mode of the current frame (MODE_MAX/MODE_AVG)
//            first     - sample is the first of its window
//            sample    - incoming lane sample
//            entry     - current line-buffer entry for this window column
//            new_entry - value to write back into the line buffer
//            result    - pooled value, meaningful on the window's last sample
// Revision : 1.0 - initial release
// ============================================================================
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic              mode,
  input  logic              first,
  input  logic [DATA_W-1:0] sample,
  input  logic [ACC_W-1:0]  entry,
  output logic [ACC_W-1:0]  new_entry,
  output logic [DATA_W-1:0] result
);

  localparam int c_SH = ACC_W - DATA_W;

  logic [ACC_W-1:0] w_ext;
  logic             w_gt;

  always_comb begin
    // Both modes keep the sample widened in the buffer so max compares and
    // sums operate on the same representation.
    if (SIGNED != 0) begin
      w_ext = {{c_SH{sample[DATA_W-1]}}, sample};
      w_gt  = $signed(w_ext) > $signed(entry);
    end else begin
      w_ext = {{c_SH{1'b0}}, sample};
      w_gt  = w_ext > entry;
    end

    if (first) begin
      new_entry = w_ext;
    end else if (mode == MODE_AVG) begin
      new_entry = entry + w_ext;
    end else begin
      new_entry = w_gt ? w_ext : entry;
    end

    // Dropping the low c_SH bits of the sum is the truncating arithmetic
    // shift; the average always fits back into DATA_W bits.
    if (mode == MODE_AVG) begin
      result = new_entry[ACC_W-1 -: DATA_W];
    end else begin
      result = new_entry[DATA_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool2d_stream.sv
`default_nettype none
// ============================================================================
// Module   : pool2d_stream
// Purpose  : Streaming non-overlapping POOLxPOOL max/average pooling over a
//            raster pixel stream of CH lanes. Partial window results live in
//            a line buffer indexed by output column, so no frame storage.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            mode                - 0 max, 1 average; captured on sof accept
//            sof                 - first pixel of a frame (with in_valid)
//            in_valid/in_ready   - input handshake
//            in_pix              - CH*DATA_W input vector, lane 0 in LSBs
//            out_valid/out_ready - output handshake, result held until taken
//            out_pix             - CH*DATA_W pooled vector
//            out_eol             - last pooled column of an output row
// Revision : 1.0 - initial release
// ============================================================================
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH     = 1,
  parameter int IMG_W  = 28,
  parameter int POOL   = 2,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               sof,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DATA_W-1:0] in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DATA_W-1:0] out_pix,
  output logic               out_eol
);

  localparam int c_LOG   = clog2(POOL);
  localparam int c_ACC_W = lane_acc_w(DATA_W, POOL);
  localparam int c_OCOLS = IMG_W / POOL;
  localparam int c_CW    = (clog2(IMG_W) < 1) ? 1 : clog2(IMG_W);
  localparam int c_OW    = (c_CW - c_LOG < 1) ? 1 : c_CW - c_LOG;

  localparam logic [c_CW-1:0]  c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_LOG-1:0] c_WIN_LAST = c_LOG'(POOL - 1);

  logic [c_CW-1:0]  r_col;
  logic [c_LOG-1:0] r_wy;
  logic             r_mode;
  logic             r_out_valid;
  logic [CH*DATA_W-1:0] r_out_pix;
  logic             r_out_eol;

  logic [CH*c_ACC_W-1:0] r_lb [c_OCOLS];

  logic                  w_accept;
  logic [c_CW-1:0]       w_col;
  logic [c_LOG-1:0]      w_wy;
  logic [c_LOG-1:0]      w_wx;
  logic [c_OW-1:0]       w_ocol;
  logic                  w_mode;
  logic                  w_first;
  logic                  w_last;
  logic                  w_eol;
  logic [CH*c_ACC_W-1:0] w_entry;
  logic [CH*c_ACC_W-1:0] w_new;
  logic [CH*DATA_W-1:0]  w_res;

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // A frame start overrides the stored position and mode for this very
  // sample, so whatever partial windows were in flight are overwritten.
  assign w_col   = sof ? '0 : r_col;
  assign w_wy    = sof ? '0 : r_wy;
  assign w_mode  = sof ? mode : r_mode;
  assign w_wx    = w_col[c_LOG-1:0];
  assign w_ocol  = c_OW'(w_col >> c_LOG);
  assign w_first = (w_wx == '0) && (w_wy == '0);
  assign w_last  = (w_wx == c_WIN_LAST) && (w_wy == c_WIN_LAST);
  assign w_eol   = (w_col == c_COL_LAST);
  assign w_entry = r_lb[w_ocol];

  for (genvar g = 0; g < CH; g++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (c_ACC_W),
      .SIGNED (SIGNED)
    ) u_lane (
      .mode      (w_mode),
      .first     (w_first),
      .sample    (in_pix[g*DATA_W +: DATA_W]),
      .entry     (w_entry[g*c_ACC_W +: c_ACC_W]),
      .new_entry (w_new[g*c_ACC_W +: c_ACC_W]),
      .result    (w_res[g*DATA_W +: DATA_W])
    );
  end

  // Line buffer needs no reset: every window's first sample overwrites it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[w_ocol] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_wy        <= '0;
      r_mode      <= MODE_MAX;
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
      r_out_eol   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode <= w_mode;
        if (w_col == c_COL_LAST) begin
          r_col <= '0;
          r_wy  <= (w_wy == c_WIN_LAST) ? '0 : w_wy + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_wy  <= w_wy;
        end
      end

      // A completing window may replace a result being taken this cycle.
      if (w_accept && w_last) begin
        r_out_valid <= 1'b1;
        r_out_pix   <= w_res;
        r_out_eol   <= w_eol;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign out_eol   = r_out_eol;

endmodule
`default_nettype wire
